// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the N-way instruction cache.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL_REQ,
    REFILL_DATA,
    INVAL
  } state_t;

  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int offset_bits(input int line_size);
    return log2(line_size);
  endfunction

  function automatic int index_bits(input int cache_size, input int line_size, input int num_ways);
    return log2(cache_size / line_size / num_ways);
  endfunction

  function automatic int tag_bits(input int addr_width, input int cache_size,
                                  input int line_size, input int num_ways);
    return addr_width - offset_bits(line_size) - index_bits(cache_size, line_size, num_ways);
  endfunction

  function automatic int words_per_line(input int line_size);
    return line_size / 4;
  endfunction

  // Geometry of the default 4 KiB, 16 B line, 4-way, 32-bit address build.
  localparam int OFFSET_W_DEF = offset_bits(16);
  localparam int INDEX_W_DEF  = index_bits(4096, 16, 4);
  localparam int TAG_W_DEF    = tag_bits(32, 4096, 16, 4);
  localparam int WORDS_DEF    = words_per_line(16);

endpackage

// File: rtl/icache_plru_tree.sv
// Combinational tree-PLRU: victim walk and path update for one set.
// Node k has children 2k+1 (left) and 2k+2 (right); a 0 bit points the victim left.
module icache_plru_tree
  import icache_pkg::*;
#(
  parameter int NUM_WAYS = 4
) (
  input  logic [NUM_WAYS-2:0]       bits_i,
  input  logic [log2(NUM_WAYS)-1:0] access_way_i,
  output logic [log2(NUM_WAYS)-1:0] victim_o,
  output logic [NUM_WAYS-2:0]       bits_o
);
  localparam int WAY_W = log2(NUM_WAYS);

  logic [WAY_W-1:0] walk;

  always_comb begin
    walk = '0;
    for (int l = 0; l < WAY_W; l++) begin
      for (int p = 0; p < (1 << l); p++) begin
        if (int'(walk >> (WAY_W - l)) == p) walk[WAY_W-1-l] = bits_i[(1 << l) - 1 + p];
      end
    end
  end

  assign victim_o = walk;

  always_comb begin
    bits_o = bits_i;
    for (int l = 0; l < WAY_W; l++) begin
      for (int p = 0; p < (1 << l); p++) begin
        if (int'(access_way_i >> (WAY_W - l)) == p)
          bits_o[(1 << l) - 1 + p] = ~access_way_i[WAY_W-1-l];
      end
    end
  end

endmodule

// File: rtl/icache_nway.sv
// Set-associative instruction cache with tree-PLRU replacement and burst refill.
// Define ICACHE_EARLY_RESTART_EN to deliver the fetched word as soon as its beat arrives.
module icache_nway
  import icache_pkg::*;
#(
  parameter int CACHE_SIZE = 4096,
  parameter int LINE_SIZE  = 16,
  parameter int NUM_WAYS   = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_flush,
  output logic                  cpu_ready,
  output logic                  cpu_rvalid,
  output logic [31:0]           cpu_rdata,
  input  logic                  inv_req,
  output logic                  inv_done,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_len,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rlast
);
  localparam int WORDS   = words_per_line(LINE_SIZE);
  localparam int SETS    = CACHE_SIZE / LINE_SIZE / NUM_WAYS;
  localparam int OFF_W   = offset_bits(LINE_SIZE);
  localparam int IDX_W   = index_bits(CACHE_SIZE, LINE_SIZE, NUM_WAYS);
  localparam int TAG_W   = tag_bits(ADDR_WIDTH, CACHE_SIZE, LINE_SIZE, NUM_WAYS);
  localparam int WAY_W   = log2(NUM_WAYS);
  localparam int WSEL_W  = (OFF_W > 2) ? OFF_W - 2 : 1;
  localparam int DATA_AW = IDX_W + WAY_W + WSEL_W;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  flush_q, flush_d;
  logic [WAY_W-1:0]      victim_q, victim_d;
  logic [WSEL_W-1:0]     beat_q, beat_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;

  logic [31:0]         data_q  [1 << DATA_AW];
  logic [TAG_W-1:0]    tag_q   [SETS * NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [SETS];
  logic [NUM_WAYS-2:0] plru_q  [SETS];

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic [WSEL_W-1:0]   word;
  logic [NUM_WAYS-1:0] hit_vec;
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic                any_inv;
  logic [WAY_W-1:0]    inv_way;
  logic [WAY_W-1:0]    plru_way, plru_victim;
  logic [NUM_WAYS-2:0] plru_next;
  logic                dwr_en, tag_wr, plru_wr, inv_all;
  logic                unused_addr_bits;

  assign idx  = addr_q[OFF_W +: IDX_W];
  assign tag  = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign word = addr_q[2 +: WSEL_W];
  assign unused_addr_bits = ^addr_q[1:0];

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_vec[w] = valid_q[idx][w] && (tag_q[{idx, WAY_W'(w)}] == tag);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
    // Descending scan so the lowest-numbered invalid way wins.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign hit = |hit_vec;

  icache_plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .bits_i       (plru_q[idx]),
    .access_way_i (plru_way),
    .victim_o     (plru_victim),
    .bits_o       (plru_next)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    flush_d  = flush_q;
    victim_d = victim_q;
    beat_d   = beat_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    plru_way = victim_q;
    dwr_en   = 1'b0;
    tag_wr   = 1'b0;
    plru_wr  = 1'b0;
    inv_all  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (inv_req) begin
          state_d = INVAL;
        end else if (cpu_req && !cpu_flush) begin
          addr_d  = cpu_addr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (cpu_flush) begin
          state_d = IDLE;
        end else if (hit) begin
          rdata_d  = data_q[{idx, hit_way, word}];
          rvalid_d = 1'b1;
          plru_way = hit_way;
          plru_wr  = 1'b1;
          state_d  = IDLE;
        end else begin
          victim_d = any_inv ? inv_way : plru_victim;
          state_d  = REFILL_REQ;
        end
      end
      REFILL_REQ: begin
        flush_d = cpu_flush;
        beat_d  = '0;
        state_d = REFILL_DATA;
      end
      REFILL_DATA: begin
        if (cpu_flush) flush_d = 1'b1;
        if (mem_rvalid) begin
          dwr_en = 1'b1;
          beat_d = beat_q + 1'b1;
`ifdef ICACHE_EARLY_RESTART_EN
          if (beat_q == word && !flush_q && !cpu_flush) begin
            rdata_d  = mem_rdata;
            rvalid_d = 1'b1;
          end
`endif
          if (mem_rlast) begin
            tag_wr  = 1'b1;
            plru_wr = 1'b1;
            flush_d = 1'b0;
            state_d = IDLE;
`ifndef ICACHE_EARLY_RESTART_EN
            if (!flush_q && !cpu_flush) begin
              // The last beat is not yet in the array, so take it straight from the bus.
              rdata_d  = (beat_q == word) ? mem_rdata : data_q[{idx, victim_q, word}];
              rvalid_d = 1'b1;
            end
`endif
          end
        end
      end
      INVAL: begin
        inv_all = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      flush_q  <= 1'b0;
      victim_q <= '0;
      beat_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      flush_q  <= flush_d;
      victim_q <= victim_d;
      beat_q   <= beat_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      if (inv_all) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
          plru_q[s]  <= '0;
        end
      end else begin
        if (tag_wr) valid_q[idx][victim_q] <= 1'b1;
        if (plru_wr) plru_q[idx] <= plru_next;
      end
    end
  end

  // Data and tag storage carries no reset; valid bits alone qualify its contents.
  always_ff @(posedge clk) begin
    if (dwr_en) data_q[{idx, victim_q, beat_q}] <= mem_rdata;
    if (tag_wr) tag_q[{idx, victim_q}] <= tag;
  end

  assign cpu_ready  = (state_q == IDLE) && !inv_req;
  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rdata_q;
  assign inv_done   = (state_q == INVAL);
  assign mem_req    = (state_q == REFILL_REQ);
  assign mem_addr   = mem_req ? {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_len    = mem_req ? 8'(WORDS - 1) : 8'd0;

endmodule

// File: tb/tb_icache_nway.sv
// Directed and randomized bench for icache_nway against a set/tag/tree-PLRU reference model.
module tb_icache_nway;

`ifdef ICACHE_EARLY_RESTART_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        cpu_flush = 1'b0;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        inv_req = 1'b0;
  logic        inv_done;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_len;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rlast = 1'b0;

  int tests = 0;
  int fails = 0;

  icache_nway dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_flush(cpu_flush),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .inv_req(inv_req), .inv_done(inv_done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Reference model: 64 sets x 4 ways, 16-byte lines, heap-ordered PLRU tree per set.
  bit          m_valid [64][4];
  int unsigned m_tag   [64][4];
  bit          m_tree  [64][3];

  function automatic int set_of(input logic [31:0] a);  return int'((a >> 4) & 32'd63); endfunction
  function automatic int unsigned tag_of(input logic [31:0] a); return a >> 10; endfunction

  function automatic logic [31:0] memval(input logic [31:0] a);
    if ((a >> 4) == 32'h0800_0000) return (((a >> 2) & 32'd3) + 32'd1) * 32'h11;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int m_lookup(input logic [31:0] a);
    for (int w = 0; w < 4; w++)
      if (m_valid[set_of(a)][w] && m_tag[set_of(a)][w] == tag_of(a)) return w;
    return -1;
  endfunction

  function automatic int m_victim(input int s);
    int node;
    for (int w = 0; w < 4; w++) if (!m_valid[s][w]) return w;
    node = 0;
    while (node < 3) node = 2 * node + 1 + int'(m_tree[s][node]);
    return node - 3;
  endfunction

  task automatic m_touch(input int s, input int w);
    int node, p;
    node = w + 3;
    while (node > 0) begin
      p = (node - 1) / 2;
      m_tree[s][p] = (node == 2 * p + 1);
      node = p;
    end
  endtask

  task automatic m_clear();
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 1'b0;
        if (w < 3) m_tree[s][w] = 1'b0;
      end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic inval();
    inv_req = 1'b1;
    #1;
    chk("inv_ready_low", cpu_ready, 0);
    step();
    chk("inv_done_pulse", inv_done, 1);
    inv_req = 1'b0;
    m_clear();
    step();
    chk("inv_done_end", inv_done, 0);
  endtask

  // flush_at: -1 none, 0 during lookup, k>=1 together with beat k-1.
  task automatic fetch(input logic [31:0] addr, input int flush_at, input bit inv_mid);
    int  s, wd, way, vic, n;
    bit  flushed, exp_v;
    s  = set_of(addr);
    wd = int'((addr >> 2) & 32'd3);
    n  = 0;
    while (cpu_ready !== 1'b1 && n < 20) begin step(); n++; end
    chk("ready_idle", cpu_ready, 1);
    cpu_req  = 1'b1;
    cpu_addr = addr;
    step();
    cpu_req = 1'b0;
    chk("ready_busy", cpu_ready, 0);
    chk("lookup_rvalid", cpu_rvalid, 0);
    way = m_lookup(addr);
    if (flush_at == 0) begin
      cpu_flush = 1'b1;
      step();
      cpu_flush = 1'b0;
      chk("lk_flush_rvalid", cpu_rvalid, 0);
      chk("lk_flush_memreq", mem_req, 0);
      return;
    end
    if (way >= 0) begin
      step();
      chk("hit_rvalid", cpu_rvalid, 1);
      chk("hit_rdata", cpu_rdata, memval(addr));
      chk("hit_memreq", mem_req, 0);
      m_touch(s, way);
      step();
      chk("hit_pulse_end", cpu_rvalid, 0);
      return;
    end
    vic = m_victim(s);
    step();
    chk("miss_memreq", mem_req, 1);
    chk("miss_memaddr", mem_addr, addr & 32'hFFFF_FFF0);
    chk("miss_memlen", mem_len, 3);
    if ($urandom_range(0, 1) == 1) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; mem_rlast = 1'b1;
    end
    step();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    chk("memreq_single", mem_req, 0);
    flushed = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 1)) begin
        step();
        chk("gap_rvalid", cpu_rvalid, 0);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = memval((addr & 32'hFFFF_FFF0) | (i << 2));
      mem_rlast  = (i == 3);
      if (flush_at == i + 1) begin cpu_flush = 1'b1; flushed = 1'b1; end
      if (inv_mid && i == 1) inv_req = 1'b1;
      step();
      mem_rvalid = 1'b0; mem_rlast = 1'b0; cpu_flush = 1'b0;
      exp_v = EARLY ? (i == wd && !flushed) : (i == 3 && !flushed);
      chk("beat_rvalid", cpu_rvalid, exp_v);
      if (exp_v) chk("beat_rdata", cpu_rdata, memval(addr));
      chk("beat_ready", cpu_ready, (i == 3 && !inv_req) ? 1 : 0);
      chk("beat_invdone", inv_done, 0);
    end
    m_valid[s][vic] = 1'b1;
    m_tag[s][vic]   = tag_of(addr);
    m_touch(s, vic);
    step();
    chk("fill_pulse_end", cpu_rvalid, 0);
    if (inv_mid) begin
      chk("mid_inv_done", inv_done, 1);
      inv_req = 1'b0;
      m_clear();
      step();
      chk("mid_inv_end", inv_done, 0);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rvalid"}, cpu_rvalid, 0);
    chk({tag, "_rdata"}, cpu_rdata, 0);
    chk({tag, "_memreq"}, mem_req, 0);
    chk({tag, "_memaddr"}, mem_addr, 0);
    chk({tag, "_memlen"}, mem_len, 0);
    chk({tag, "_invdone"}, inv_done, 0);
  endtask

  logic [31:0] a;
  int          sets_pool [3] = '{5, 35, 63};

  initial begin
    int r, fa;
    m_clear();
    #1;
    chk_outputs_zero("reset");
    chk("reset_ready", cpu_ready, 1);
    step(); step();
    rst = 1'b0;
    step();

    // Cold miss on a known line, then re-fetch as a two-cycle hit.
    fetch(32'h8000_0004, -1, 1'b0);
    fetch(32'h8000_0004, -1, 1'b0);
    fetch(32'h8000_0000, -1, 1'b0);

    // A request together with cpu_flush in IDLE is not accepted.
    cpu_req = 1'b1; cpu_flush = 1'b1; cpu_addr = 32'h0000_0100;
    step();
    cpu_req = 1'b0; cpu_flush = 1'b0;
    chk("idle_flush_ready", cpu_ready, 1);
    step();
    chk("idle_flush_memreq", mem_req, 0);
    chk("idle_flush_rvalid", cpu_rvalid, 0);

    // Five tags into one set: ways touched 0,1,2,3,0 then a fifth tag evicts way 2.
    inval();
    for (int k = 0; k < 4; k++) fetch(32'h0000_1230 + k * 32'h400, -1, 1'b0);
    fetch(32'h0000_1230, -1, 1'b0);
    fetch(32'h0000_1230 + 4 * 32'h400, -1, 1'b0);
    fetch(32'h0000_1230 + 3 * 32'h400, -1, 1'b0);
    fetch(32'h0000_1230 + 1 * 32'h400, -1, 1'b0);
    fetch(32'h0000_1230, -1, 1'b0);
    fetch(32'h0000_1230 + 2 * 32'h400, -1, 1'b0);

    // Flush on the second beat still installs the line.
    fetch(32'h0000_3348, 2, 1'b0);
    fetch(32'h0000_3348, -1, 1'b0);
    // Flush during lookup.
    fetch(32'h0000_3348, 0, 1'b0);
    fetch(32'h0000_3340, -1, 1'b0);

    // Invalidate raised mid-refill waits for rlast; the line is gone afterwards.
    fetch(32'h0000_5554, -1, 1'b1);
    fetch(32'h0000_5554, -1, 1'b0);

    // Word 0 miss, last-word miss.
    fetch(32'h0000_7700, -1, 1'b0);
    fetch(32'h0000_790C, -1, 1'b0);

    // Reset in the middle of a burst.
    inval();
    cpu_req = 1'b1; cpu_addr = 32'h0000_2008;
    step();
    cpu_req = 1'b0;
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1; mem_rdata = memval(32'h0000_2000 | (i << 2)); mem_rlast = 1'b0;
      step();
    end
    rst = 1'b1;
    #1;
    mem_rvalid = 1'b0;
    chk_outputs_zero("midburst_rst");
    step();
    rst = 1'b0;
    m_clear();
    step();
    fetch(32'h0000_2008, -1, 1'b0);
    fetch(32'h0000_2008, -1, 1'b0);

    // Randomized traffic over a few contended sets.
    for (int t = 0; t < 90; t++) begin
      a = 32'h4000_0000 | ($urandom_range(0, 5) << 10) |
          (sets_pool[$urandom_range(0, 2)] << 4) | ($urandom_range(0, 3) << 2);
      r  = int'($urandom_range(0, 99));
      fa = (r < 8) ? 0 : (r < 18) ? int'($urandom_range(1, 4)) : -1;
      if (r >= 97) inval();
      fetch(a, fa, (r >= 93 && r < 97));
    end

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_nway.md
ICACHE_NWAY -- requirements
Module: icache_nway

Interface
- REQ-001 SHALL have parameter CACHE_SIZE, default 4096: total data capacity in bytes.
- REQ-002 SHALL have parameter LINE_SIZE, default 16: line bytes, power of 2, at least 4.
- REQ-003 SHALL have parameter NUM_WAYS, default 4: associativity, power of 2, at least 2.
- REQ-004 SHALL have parameter ADDR_WIDTH, default 32: address width.
- REQ-005 SHALL have these ports:
  - clk  in  1  clock.
  - rst  in  1  reset, asynchronous, active-high.
  - cpu_req  in  1  fetch request; sampled only when cpu_ready=1.
  - cpu_addr  in  ADDR_WIDTH  fetch address, word aligned.
  - cpu_flush  in  1  cancel the outstanding fetch.
  - cpu_ready  out  1  cache can accept a request.
  - cpu_rvalid  out  1  single-cycle pulse, data valid.
  - cpu_rdata  out  32  instruction word.
  - inv_req  in  1  invalidate-all request; level, held until inv_done.
  - inv_done  out  1  single-cycle pulse, invalidation complete.
  - mem_req  out  1  single-cycle burst request pulse.
  - mem_addr  out  ADDR_WIDTH  line-aligned burst address.
  - mem_len  out  8  beats minus 1.
  - mem_rvalid  in  1  beat valid.
  - mem_rdata  in  32  beat data.
  - mem_rlast  in  1  last beat of the burst.

Function
- REQ-006 SHALL decompose addresses as follows:
  - offset = log2(LINE_SIZE) bits.
  - index = log2(CACHE_SIZE/LINE_SIZE/NUM_WAYS) bits.
  - tag = the remaining upper bits.
- REQ-007 SHALL use the states IDLE, LOOKUP, REFILL_REQ, REFILL_DATA and INVAL.
- REQ-008 cpu_ready SHALL be 1 only in IDLE, and only when inv_req=0.
- REQ-009 In IDLE, inv_req=1 SHALL take priority over cpu_req and move to INVAL.
- REQ-010 INVAL SHALL, in one cycle, clear every valid bit and every PLRU bit, pulse inv_done, and return to IDLE.
- REQ-011 In IDLE, cpu_req=1 with cpu_flush=0 SHALL capture cpu_addr and move to LOOKUP.
- REQ-012 A LOOKUP hit SHALL register cpu_rdata and pulse cpu_rvalid the next cycle, giving a hit latency of 2 cycles from acceptance. The PLRU for the set SHALL be updated and the state SHALL return to IDLE.
- REQ-013 A LOOKUP miss SHALL choose the victim way as the lowest-index invalid way, or the tree-PLRU victim if all ways are valid, then move to REFILL_REQ.
- REQ-014 REFILL_REQ SHALL drive mem_req=1 for exactly one cycle, with mem_addr = the line-aligned address and mem_len = LINE_SIZE/4-1, then move to REFILL_DATA.
- REQ-015 Beats SHALL be written to words 0..LINE_SIZE/4-1 in arrival order. On mem_rlast, the tag and valid bit SHALL be written, the PLRU updated to point away from the filled way, and the state SHALL return to IDLE.
- REQ-016 Tree PLRU SHALL keep NUM_WAYS-1 bits per set. An access SHALL set each node on its path to point away from the accessed way.
- REQ-017 cpu_flush in LOOKUP SHALL suppress cpu_rvalid, return to IDLE, and leave the PLRU unchanged.
- REQ-018 cpu_flush in REFILL_REQ or REFILL_DATA SHALL cause these behaviours:
  - The burst SHALL still be issued and fully drained.
  - The line SHALL be installed.
  - cpu_rvalid SHALL be suppressed for that fetch.
  - The flush SHALL be remembered until mem_rlast.
- REQ-019 cpu_flush in IDLE SHALL have no effect, and no request SHALL be accepted in the same cycle.
- REQ-020 inv_req asserted during a refill SHALL wait until the refill completes. INVAL SHALL then follow IDLE.
- REQ-021 mem_rvalid outside REFILL_DATA SHALL be ignored.
- REQ-022 cpu_rvalid SHALL pulse exactly once per accepted, unflushed request.

Reset
- REQ-023 On rst, the following SHALL hold:
  - The state SHALL be IDLE.
  - cpu_rvalid, cpu_rdata, mem_req, mem_addr, mem_len and inv_done SHALL be 0.
  - All valid bits, PLRU bits and the pending-flush flag SHALL be 0.
- REQ-024 Data and tag arrays SHALL NOT be reset.
- REQ-025 Reset asserted mid-burst SHALL abandon the burst immediately.

Configuration
- REQ-026 With ICACHE_EARLY_RESTART_EN defined, cpu_rvalid SHALL pulse in the cycle after the beat whose index equals the requested word. Later beats SHALL continue to fill, and cpu_ready SHALL stay 0 until mem_rlast.
- REQ-027 Without ICACHE_EARLY_RESTART_EN, cpu_rvalid SHALL pulse in the cycle after mem_rlast. The requested word SHALL be taken from the beat or the array.

Structure
- REQ-028 Package icache_pkg SHALL hold:
  - the state enum;
  - a log2 helper function;
  - the localparam derivations for offset, index, tag and words-per-line.
- REQ-029 Sub-module icache_plru_tree SHALL hold the combinational tree-PLRU logic: victim select plus next-bit update, parameterised by NUM_WAYS.

Verification
- REQ-030 Cold miss at 0x8000_0004: check all of the following.
  - mem_addr=0x8000_0000 and mem_len=3.
  - Beats 0x11, 0x22, 0x33, 0x44 are returned.
  - cpu_rdata=0x22.
  - A re-fetch hits with cpu_rvalid 2 cycles after acceptance.
- REQ-031 Five tags mapping to the same set with NUM_WAYS=4, after touching ways in order 0,1,2,3,0: the fifth tag replaces way 2, per the tree PLRU.
- REQ-032 cpu_flush asserted on the 2nd beat: no cpu_rvalid; all 4 beats are consumed; the next fetch to the same line hits.
- REQ-033 inv_req raised mid-refill: inv_done pulses after mem_rlast; the next fetch to the previously cached line misses.
- REQ-034 With ICACHE_EARLY_RESTART_EN, fetch word 0 on a miss: cpu_rvalid one cycle after beat 0; cpu_ready stays 0 until rlast.
- REQ-035 rst asserted mid-burst: all outputs are 0 the next cycle; the next fetch misses.
